// File: rtl/vga_pkg.sv
// Shared screen geometry, bus widths, pixel record and sink FSM encodings.
package vga_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int ADDR_W   = 17;
    localparam int COLOR_W  = 3;
    localparam int COORD_W  = 10;
    localparam int PIX_W    = ADDR_W + COLOR_W;

    // Sink FSM encodings
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_DRAIN     = 2'd1;
    localparam logic [1:0] S_CLEAR     = 2'd2;
    localparam logic [1:0] S_CLEAR_END = 2'd3;

    // One buffered write: linear framebuffer address plus color
    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [COLOR_W-1:0] color;
    } pix_t;

    // Linear framebuffer address y*w + x, truncated to the address width
    function automatic logic [ADDR_W-1:0] lin_addr(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y,
                                                   input int w);
        return ADDR_W'(y) * ADDR_W'(w) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with registered read/write pointers (one extra wrap bit
// distinguishes full from empty). A push while full is accepted only when a
// pop happens on the same edge.
module pixel_fifo
    import vga_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = PIX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    // Pointer advance on accepted push/pop
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    // Pointer registers; reset empties the FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array; contents are don't-care while empty so no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/pixel_write_sink.sv
// Accepts pixels from a sprite drawer, filters off-screen and transparent
// pixels, buffers {address,color} in a FIFO and drains them to a framebuffer
// write port. A clear request walks the whole screen writing color 0.
//
// Handshake: fb_wren/fb_address/fb_data come straight from registers and never
// depend combinationally on fb_ready. A write completes on a rising edge where
// fb_wren & fb_ready; until then the output register holds. The output
// register only takes a new FIFO entry on an edge where fb_ready is high, so a
// stalled framebuffer leaves all buffered pixels in the FIFO.
module pixel_write_sink
    import vga_pkg::ADDR_W, vga_pkg::COLOR_W, vga_pkg::COORD_W, vga_pkg::PIX_W,
           vga_pkg::S_IDLE, vga_pkg::S_DRAIN, vga_pkg::S_CLEAR, vga_pkg::S_CLEAR_END,
           vga_pkg::pix_t, vga_pkg::lin_addr;
#(
    parameter int         SCREEN_W          = vga_pkg::SCREEN_W,
    parameter int         SCREEN_H          = vga_pkg::SCREEN_H,
    parameter int         FIFO_DEPTH        = 16,
    parameter logic [2:0] TRANSPARENT_COLOR = 3'b000,
    parameter bit         TRANSPARENT_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [2:0]  color,
    input  logic        writeEn,
    input  logic        clear,
    input  logic        fb_ready,
    output logic [16:0] fb_address,
    output logic [2:0]  fb_data,
    output logic        fb_wren,
    output logic        busy,
    output logic        clear_done,
    output logic        overflow
);

    localparam logic [COORD_W-1:0] X_LIM     = COORD_W'(SCREEN_W);
    localparam logic [COORD_W-1:0] Y_LIM     = COORD_W'(SCREEN_H);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);

    // FSM state and output register
    logic [1:0]         state_q, state_d;
    logic               fb_wren_q, fb_wren_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [COLOR_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic               clr_pend_q, clr_pend_d;
    logic               overflow_q, overflow_d;

    // Input side
    logic               in_range;
    logic               transparent;
    logic               pix_pass;
    pix_t               pix_in;

    // FIFO side
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [PIX_W-1:0]   fifo_rdata;
    pix_t               fifo_head;

    // A write is still waiting for the framebuffer to take it
    logic               pending;

    assign in_range    = (x < X_LIM) && (y < Y_LIM);
    assign transparent = TRANSPARENT_EN && (color == TRANSPARENT_COLOR);
    assign pix_pass    = writeEn && in_range && !transparent;
    assign pix_in      = '{addr: lin_addr(x, y, SCREEN_W), color: color};
    assign fifo_head   = pix_t'(fifo_rdata);
    assign pending     = fb_wren_q && !fb_ready;

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset_n),
        .push_i  (pix_pass),
        .pop_i   (fifo_pop),
        .wdata_i (pix_in),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next-state, output register and clear counter control
    always_comb begin
        state_d    = state_q;
        fb_wren_d  = fb_wren_q;
        addr_d     = addr_q;
        data_d     = data_q;
        clr_cnt_d  = clr_cnt_q;
        clr_pend_d = clr_pend_q;
        fifo_pop   = 1'b0;
        unique case (state_q)
            S_IDLE, S_DRAIN: begin
                if ((clear || clr_pend_q) && !pending) begin
                    // Clear wins over drain; first clear write is address 0
                    state_d    = S_CLEAR;
                    clr_pend_d = 1'b0;
                    clr_cnt_d  = '0;
                    fb_wren_d  = 1'b1;
                    addr_d     = '0;
                    data_d     = '0;
                end else begin
                    if (clear) clr_pend_d = 1'b1;
                    if (fb_ready) begin
                        fb_wren_d = !fifo_empty;
                        fifo_pop  = !fifo_empty;
                        if (!fifo_empty) begin
                            addr_d = fifo_head.addr;
                            data_d = fifo_head.color;
                        end
                    end
                    state_d = (fifo_empty && !fb_wren_d) ? S_IDLE : S_DRAIN;
                end
            end
            S_CLEAR: begin
                if (fb_ready) begin
                    if (clr_cnt_q == LAST_ADDR) begin
                        fb_wren_d = 1'b0;
                        state_d   = S_CLEAR_END;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 17'd1;
                        addr_d    = clr_cnt_q + 17'd1;
                    end
                end
            end
            S_CLEAR_END: begin
                state_d = fifo_empty ? S_IDLE : S_DRAIN;
            end
            default: begin
                state_d   = S_IDLE;
                fb_wren_d = 1'b0;
            end
        endcase
    end

    // Sticky overflow: a filtered pixel found the FIFO full with no pop to make room
    always_comb begin
        overflow_d = overflow_q || (pix_pass && fifo_full && !fifo_pop);
    end

    // State registers; reset abandons any drain or clear immediately
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q    <= S_IDLE;
            fb_wren_q  <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            clr_cnt_q  <= '0;
            clr_pend_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fb_wren_q  <= fb_wren_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            clr_cnt_q  <= clr_cnt_d;
            clr_pend_q <= clr_pend_d;
            overflow_q <= overflow_d;
        end
    end

    assign fb_wren    = fb_wren_q;
    assign fb_address = addr_q;
    assign fb_data    = data_q;
    assign overflow   = overflow_q;
    assign clear_done = (state_q == S_CLEAR_END);
    assign busy       = !fifo_empty || fb_wren_q || clr_pend_q ||
                        (state_q == S_CLEAR) || (state_q == S_CLEAR_END);

endmodule

// File: tb/tb_pixel_write_sink.sv
// Bench for pixel_write_sink: reset values, latency, a filter vector table,
// stall/hold behaviour, overflow, full-screen clear and reset during clear.
module tb_pixel_write_sink;

  localparam int W      = 320;
  localparam int H      = 240;
  localparam int NPIX   = W * H;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [2:0]  color;
  logic        writeEn;
  logic        clear;
  logic        fb_ready;
  logic [16:0] fb_address;
  logic [2:0]  fb_data;
  logic        fb_wren;
  logic        busy;
  logic        clear_done;
  logic        overflow;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pixel_write_sink dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .x          (x),
    .y          (y),
    .color      (color),
    .writeEn    (writeEn),
    .clear      (clear),
    .fb_ready   (fb_ready),
    .fb_address (fb_address),
    .fb_data    (fb_data),
    .fb_wren    (fb_wren),
    .busy       (busy),
    .clear_done (clear_done),
    .overflow   (overflow)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [19:0] exp_q[$];
  int          wr_cnt = 0;
  int          neg_cnt = 0;
  bit          clr_expect = 1'b0;
  int          clr_addr = 0;
  int          last_clr_neg = -10;
  int          cd_cnt = 0;
  bit          prev_hold = 1'b0;
  logic [16:0] prev_addr;
  logic [2:0]  prev_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference filter/address model
  function automatic bit model_pass(input int px, input int py, input int pc);
    return (px < W) && (py < H) && (pc != 0);
  endfunction

  function automatic logic [19:0] model_word(input int px, input int py, input int pc);
    logic [16:0] a;
    logic [2:0]  c;
    a = 17'(py * W + px);
    c = 3'(pc);
    return {a, c};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [19:0] e;
    neg_cnt++;
    if (reset_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_wren", 32'(fb_wren), 32'd1);
        chk("hold_addr", 32'(fb_address), 32'(prev_addr));
        chk("hold_data", 32'(fb_data), 32'(prev_data));
      end
      if (clear_done) begin
        cd_cnt++;
        chk("clear_done_timing", 32'(neg_cnt), 32'(last_clr_neg + 1));
      end
      if (fb_wren && fb_ready) begin
        wr_cnt++;
        if (clr_expect) begin
          chk("clr_addr", 32'(fb_address), 32'(clr_addr));
          chk("clr_data", 32'(fb_data), 32'd0);
          clr_addr++;
          if (clr_addr == NPIX) begin
            clr_expect   = 1'b0;
            last_clr_neg = neg_cnt;
          end
        end else if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr=%0d data=%0d, expected no write (t=%0t)",
                   fb_address, fb_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(fb_address), 32'(e[19:3]));
          chk("wr_data", 32'(fb_data), 32'(e[2:0]));
        end
      end
      prev_hold = fb_wren && !fb_ready;
      prev_addr = fb_address;
      prev_data = fb_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle pixel strobe; expectation pushed when the model says it is kept
  task automatic send(input int px, input int py, input int pc, input bit expect_store);
    x       = 10'(px);
    y       = 10'(py);
    color   = 3'(pc);
    writeEn = 1'b1;
    if (expect_store) exp_q.push_back(model_word(px, py, pc));
    tick();
    writeEn = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b1;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int x;
    int y;
    int c;
    bit wr;
    int addr;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int n;
    int w0;

    tbl[0] = '{x: 5,    y: 2,   c: 2, wr: 1'b1, addr: 645};
    tbl[1] = '{x: 320,  y: 0,   c: 1, wr: 1'b0, addr: 0};
    tbl[2] = '{x: 0,    y: 240, c: 5, wr: 1'b0, addr: 0};
    tbl[3] = '{x: 10,   y: 10,  c: 0, wr: 1'b0, addr: 0};
    tbl[4] = '{x: 319,  y: 239, c: 7, wr: 1'b1, addr: 76799};
    tbl[5] = '{x: 0,    y: 0,   c: 1, wr: 1'b1, addr: 0};
    tbl[6] = '{x: 100,  y: 50,  c: 4, wr: 1'b1, addr: 16100};
    tbl[7] = '{x: 1023, y: 5,   c: 3, wr: 1'b0, addr: 0};

    reset_n  = 1'b1;
    x        = '0;
    y        = '0;
    color    = '0;
    writeEn  = 1'b0;
    clear    = 1'b0;
    fb_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wren", 32'(fb_wren), 32'd0);
    chk("rst_addr", 32'(fb_address), 32'd0);
    chk("rst_data", 32'(fb_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_clear_done", 32'(clear_done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    tick();
    reset_n = 1'b0;
    tick();
    tick();

    // Latency: enqueue at edge N, output register at N+1, write visible before N+2
    x = 10'd5; y = 10'd2; color = 3'b010; writeEn = 1'b1;
    exp_q.push_back(model_word(5, 2, 2));
    @(posedge clk);
    #1 writeEn = 1'b0;
    @(negedge clk);
    chk("lat_wren_n", 32'(fb_wren), 32'd0);
    @(negedge clk);
    chk("lat_wren_n1", 32'(fb_wren), 32'd1);
    chk("lat_addr", 32'(fb_address), 32'd645);
    chk("lat_data", 32'(fb_data), 32'd2);
    tick();
    repeat (3) tick();
    chk("lat_busy_after", 32'(busy), 32'd0);

    // Table-driven filter and address vectors
    for (int i = 0; i < 8; i++) begin
      w0 = wr_cnt;
      if (tbl[i].wr) exp_q.push_back({17'(tbl[i].addr), 3'(tbl[i].c)});
      send(tbl[i].x, tbl[i].y, tbl[i].c, 1'b0);
      repeat (4) tick();
      chk("tbl_writes", 32'(wr_cnt - w0), 32'(tbl[i].wr));
      chk("tbl_overflow", 32'(overflow), 32'd0);
      chk("tbl_busy", 32'(busy), 32'd0);
    end

    // Stalled framebuffer then alternating ready: outputs hold, nothing lost
    fb_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(i * 3, 7, 1 + (i % 7), 1'b1);
    chk("stall_no_write", 32'(fb_wren), 32'd0);
    for (int i = 0; i < 40; i++) begin
      fb_ready = i[0];
      tick();
    end
    fb_ready = 1'b1;
    repeat (4) tick();
    chk("toggle_drained", 32'(exp_q.size()), 32'd0);
    chk("toggle_busy", 32'(busy), 32'd0);

    // Random pixels with random framebuffer back-pressure
    for (int i = 0; i < 300; i++) begin
      int px;
      int py;
      int pc;
      px = $urandom_range(0, 400);
      py = $urandom_range(0, 300);
      pc = $urandom_range(0, 7);
      x = 10'(px);
      y = 10'(py);
      color = 3'(pc);
      writeEn = ($urandom_range(0, 3) == 0);
      if (writeEn && model_pass(px, py, pc)) exp_q.push_back(model_word(px, py, pc));
      fb_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    writeEn  = 1'b0;
    fb_ready = 1'b1;
    repeat (20) tick();
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_overflow", 32'(overflow), 32'd0);

    // Overflow: 17 pixels into a stalled sink, 16 kept
    fb_ready = 1'b0;
    for (int i = 0; i < 17; i++) send(i + 20, 100, (i % 7) + 1, i < 16);
    tick();
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_busy", 32'(busy), 32'd1);
    w0 = wr_cnt;
    fb_ready = 1'b1;
    repeat (25) tick();
    chk("ovf_write_count", 32'(wr_cnt - w0), 32'd16);
    chk("ovf_drained", 32'(exp_q.size()), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    do_reset();
    chk("ovf_reset_clears", 32'(overflow), 32'd0);

    // Full clear with a pixel injected mid-clear and an ignored second pulse
    fb_ready   = 1'b1;
    clr_expect = 1'b1;
    clr_addr   = 0;
    cd_cnt     = 0;
    clear      = 1'b1;
    tick();
    clear = 1'b0;
    n = 0;
    while (clr_addr < 30000 && n < 40000) begin
      tick();
      n++;
    end
    chk("clr_progress_a", 32'(clr_addr >= 30000), 32'd1);
    send(7, 3, 5, 1'b1);
    n = 0;
    while (clr_addr < 40000 && n < 20000) begin
      tick();
      n++;
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n = 0;
    while (cd_cnt == 0 && n < 50000) begin
      tick();
      n++;
    end
    chk("clr_done_seen", 32'(cd_cnt > 0), 32'd1);
    repeat (6) tick();
    chk("clr_count", 32'(clr_addr), 32'(NPIX));
    chk("clr_done_once", 32'(cd_cnt), 32'd1);
    chk("clr_inject_written", 32'(exp_q.size()), 32'd0);
    chk("clr_busy_after", 32'(busy), 32'd0);

    // Reset in the middle of a clear
    clr_expect = 1'b1;
    clr_addr   = 0;
    clear      = 1'b1;
    tick();
    clear = 1'b0;
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (fb_address == 17'd1000) break;
      n++;
    end
    chk("rclr_reached", 32'(n < 2000), 32'd1);
    #2 reset_n = 1'b1;
    clr_expect = 1'b0;
    w0 = wr_cnt;
    #1;
    chk("rclr_wren", 32'(fb_wren), 32'd0);
    chk("rclr_busy", 32'(busy), 32'd0);
    chk("rclr_addr", 32'(fb_address), 32'd0);
    tick();
    tick();
    reset_n = 1'b0;
    repeat (50) tick();
    chk("rclr_no_writes", 32'(wr_cnt - w0), 32'd0);
    chk("rclr_idle_busy", 32'(busy), 32'd0);
    send(1, 1, 6, 1'b1);
    repeat (4) tick();
    chk("rclr_resume", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
